// File: rtl/phy_link_poller.sv
// phy_link_poller: brings the RGMII PHY out of hardware reset, optionally writes an initial
// BMCR value, then periodically reads the PHY-specific status register over the MDIO master's
// cmd/rsp handshake. The decoded link state and speed drive the RGMII interface.
module phy_link_poller #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [4:0]  STAT_REG    = 5'h11,
    parameter int unsigned LINK_BIT    = 10,
    parameter int unsigned SPEED_LSB   = 14,
    parameter bit          INIT_EN     = 1'b1,
    parameter logic [15:0] INIT_BMCR   = 16'h1340,
    parameter int unsigned RST_HOLD    = 1_250_000,
    parameter int unsigned RST_WAIT    = 6_250_000,
    parameter int unsigned POLL_CYCLES = 1_250_000,
    parameter int unsigned RSP_TIMEOUT = 65_535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        phy_rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic [1:0]  speed,
    output logic        link_up,
    output logic        link_change,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        StRstHold,
        StRstWait,
        StInitWr,
        StIdle,
        StRdStat,
        StWaitRsp,
        StDecode
    } state_e;

    state_e      state_q;
    logic [31:0] cnt_q;       // shared timer; every state clears it on entry
    logic [15:0] rdata_q;     // status word captured with rsp_valid, decoded next cycle

    logic        dec_link;
    logic [1:0]  dec_fld;
    logic [1:0]  dec_speed;

    assign cmd_phy_addr = PHY_ADDR;

    // Decode of the captured status word; a reserved speed field or a down link keeps the
    // last speed so the MAC clocking does not glitch while the PHY renegotiates.
    always_comb begin
        dec_link  = rdata_q[LINK_BIT];
        dec_fld   = rdata_q[SPEED_LSB +: 2];
        dec_speed = speed;
        if (dec_link && (dec_fld != 2'b11)) begin
            dec_speed = dec_fld;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRstHold;
            cnt_q        <= 32'd0;
            rdata_q      <= 16'd0;
            phy_rst_n    <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_reg_addr <= 5'd0;
            cmd_wdata    <= 16'd0;
            speed        <= 2'b10;
            link_up      <= 1'b0;
            link_change  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            link_change <= 1'b0;
            unique case (state_q)
                StRstHold: begin
                    phy_rst_n <= 1'b0;
                    if (cnt_q == RST_HOLD - 1) begin
                        state_q   <= StRstWait;
                        cnt_q     <= 32'd0;
                        phy_rst_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StRstWait: begin
                    if (cnt_q == RST_WAIT - 1) begin
                        cnt_q <= 32'd0;
                        if (INIT_EN) begin
                            state_q      <= StInitWr;
                            cmd_valid    <= 1'b1;
                            cmd_write    <= 1'b1;
                            cmd_reg_addr <= 5'd0;
                            cmd_wdata    <= INIT_BMCR;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StInitWr, StRdStat: begin
                    // Command fields were loaded on entry and stay put until accepted.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state_q   <= StWaitRsp;
                        cnt_q     <= 32'd0;
                    end
                end
                StIdle: begin
                    if (!enable) begin
                        cnt_q <= 32'd0;
                    end else if (cnt_q == POLL_CYCLES - 1) begin
                        cnt_q        <= 32'd0;
                        state_q      <= StRdStat;
                        cmd_valid    <= 1'b1;
                        cmd_write    <= 1'b0;
                        cmd_reg_addr <= STAT_REG;
                        cmd_wdata    <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StWaitRsp: begin
                    // A response in the expiry cycle still counts as a normal response.
                    if (rsp_valid) begin
                        timeout_err <= 1'b0;
                        cnt_q       <= 32'd0;
                        if (cmd_write) begin
                            state_q <= StIdle;
                        end else begin
                            rdata_q <= rsp_rdata;
                            state_q <= StDecode;
                        end
                    end else if (cnt_q == RSP_TIMEOUT - 1) begin
                        timeout_err <= 1'b1;
                        link_up     <= 1'b0;
                        link_change <= link_up;
                        state_q     <= StIdle;
                        cnt_q       <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StDecode: begin
                    link_up     <= dec_link;
                    speed       <= dec_speed;
                    link_change <= (dec_link != link_up) || (dec_speed != speed);
                    state_q     <= StIdle;
                    cnt_q       <= 32'd0;
                end
                default: begin
                    state_q <= StRstHold;
                    cnt_q   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_link_poller.sv
// Randomized bench for phy_link_poller: an MDIO responder drives the handshake and pushes the
// expected decoded outputs into a scoreboard; an independent monitor checks them on the cycle
// they are due.
module tb_phy_link_poller;

    localparam int unsigned RH = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned PC = 20;
    localparam int unsigned RT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_rdata = 16'd0;
    logic        phy_rst_n, cmd_valid, cmd_write, link_up, link_change, timeout_err;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  speed;

    phy_link_poller #(
        .PHY_ADDR   (5'd1),
        .STAT_REG   (5'h11),
        .LINK_BIT   (10),
        .SPEED_LSB  (14),
        .INIT_EN    (1'b1),
        .INIT_BMCR  (16'h1340),
        .RST_HOLD   (RH),
        .RST_WAIT   (RW),
        .POLL_CYCLES(PC),
        .RSP_TIMEOUT(RT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .phy_rst_n   (phy_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_phy_addr(cmd_phy_addr),
        .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .speed       (speed),
        .link_up     (link_up),
        .link_change (link_change),
        .timeout_err (timeout_err)
    );

    always #4 clk = ~clk;

    // Edge number since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [1:0] spd;
        logic       lu;
        logic       lc;
        logic       te;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [1:0] m_spd = 2'b10;
    logic       m_lu  = 1'b0;
    int         n_lc_exp  = 0;
    int         n_lc_seen = 0;
    bit         abort = 1'b0;
    int         next_at;

    // Reference model: link bit and speed field decoded straight from the status word.
    task automatic push_read(input int due, input logic [15:0] d);
        logic       nl;
        logic [1:0] f, ns;
        logic       lc;
        nl = d[10];
        f  = d[15:14];
        ns = (nl && f != 2'b11) ? f : m_spd;
        lc = (nl != m_lu) || (ns != m_spd);
        m_lu  = nl;
        m_spd = ns;
        if (lc) n_lc_exp++;
        sb.push_back('{due, ns, nl, lc, 1'b0});
    endtask

    task automatic push_timeout(input int due);
        logic lc;
        lc   = m_lu;
        m_lu = 1'b0;
        if (lc) n_lc_exp++;
        sb.push_back('{due, m_spd, 1'b0, lc, 1'b1});
    endtask

    task automatic push_write(input int due);
        sb.push_back('{due, m_spd, m_lu, 1'b0, 1'b0});
    endtask

    // Monitor: compares the scoreboard head on its due cycle, tallies link_change pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (link_change) n_lc_seen++;
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    mon_e = sb.pop_front();
                    chk("sb_slot", cyc, mon_e.due);
                    chk("speed", {30'd0, speed}, {30'd0, mon_e.spd});
                    chk("link_up", {31'd0, link_up}, {31'd0, mon_e.lu});
                    chk("link_change", {31'd0, link_change}, {31'd0, mon_e.lc});
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, mon_e.te});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input int exp_at);
        int t = 0;
        while (!cmd_valid && t < 300) begin
            tick();
            t++;
        end
        chk("cmd_valid_arrives", {31'd0, cmd_valid}, 32'd1);
        if (!cmd_valid) abort = 1'b1;
        else if (exp_at >= 0) chk("cmd_start_cycle", cyc, exp_at);
    endtask

    // One MDIO transaction from the responder side. lat=0 picks a random latency.
    task automatic do_txn(input bit to, input logic [15:0] d, input int lat, input bit dis,
                          input bit is_wr, input int hold, input bit stray);
        logic        w;
        logic [4:0]  ra;
        logic [15:0] wd;
        int          h, l, dly;
        bit          seen;
        wait_cmd(next_at);
        if (abort) return;
        w  = cmd_write;
        ra = cmd_reg_addr;
        wd = cmd_wdata;
        chk("cmd_write", {31'd0, w}, {31'd0, is_wr});
        chk("cmd_reg_addr", {27'd0, ra}, is_wr ? 32'd0 : 32'h11);
        chk("cmd_phy_addr", {27'd0, cmd_phy_addr}, 32'd1);
        if (is_wr) chk("cmd_wdata", {16'd0, wd}, 32'h1340);
        dly = (hold >= 0) ? hold : int'($urandom_range(0, 3));
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("cmd_stable", {9'd0, cmd_valid, w, ra, cmd_wdata}, {9'd0, 1'b1, w, ra, wd});
        end
        cmd_ready = 1'b1;
        tick();
        h = cyc;
        cmd_ready = 1'b0;
        chk("cmd_drop", {31'd0, cmd_valid}, 32'd0);
        if (dis) enable = 1'b0;
        if (to) begin
            push_timeout(h + RT);
            repeat (RT) tick();
            next_at = h + RT + PC;
        end else begin
            l = (lat > 0) ? lat : int'($urandom_range(1, RT));
            repeat (l - 1) tick();
            rsp_valid = 1'b1;
            rsp_rdata = d;
            if (is_wr) push_write(h + l + 1);
            else       push_read(h + l + 1, d);
            tick();
            rsp_valid = 1'b0;
            rsp_rdata = 16'($urandom);
            next_at = h + l + (is_wr ? PC : PC + 1);
        end
        if (stray) begin
            // Response outside WAIT_RSP; it must leave no trace.
            repeat (3) tick();
            rsp_valid = 1'b1;
            rsp_rdata = 16'($urandom);
            tick();
            rsp_valid = 1'b0;
        end
        if (dis) begin
            seen = 1'b0;
            repeat (3 * PC) begin
                tick();
                if (cmd_valid) seen = 1'b1;
            end
            chk("parked_no_cmd", {31'd0, seen}, 32'd0);
            enable = 1'b1;
            next_at = cyc + PC;
        end
    endtask

    bit          d_to[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic [15:0] d_dat[8] = '{16'h8400, 16'h8400, 16'h4400, 16'h0000,
                              16'h0000, 16'h8400, 16'hC400, 16'h0400};
    int          d_lat[8] = '{0, 1, 0, 32, 0, 0, 0, 0};
    bit          d_dis[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #20;
        chk("rst_phy_rst_n", {31'd0, phy_rst_n}, 32'd0);
        chk("rst_cmd", {5'd0, cmd_valid, cmd_write, cmd_reg_addr, cmd_wdata}, 32'd0);
        chk("rst_status", {27'd0, speed, link_up, link_change, timeout_err}, 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= int'(RH + RW); k++) begin
            tick();
            chk("power_up_seq", {30'd0, phy_rst_n, cmd_valid},
                {30'd0, (k >= int'(RH)), (k >= int'(RH + RW))});
        end
        next_at = int'(RH + RW);
        // BMCR write with cmd_ready held off for 20 cycles.
        do_txn(1'b0, 16'h0000, 0, 1'b0, 1'b1, 20, 1'b0);
        for (int i = 0; i < 8 && !abort; i++) begin
            do_txn(d_to[i], d_dat[i], d_lat[i], d_dis[i], 1'b0, -1, 1'b0);
        end
        for (int i = 0; i < 24 && !abort; i++) begin
            do_txn(($urandom_range(0, 7) == 0), 16'($urandom), 0,
                   ($urandom_range(0, 7) == 0), 1'b0, -1, ($urandom_range(0, 3) == 0));
        end
        if (!abort) do_txn(1'b0, 16'h8400, 0, 1'b0, 1'b0, -1, 1'b0);
        repeat (4) tick();
        chk("sb_drained", sb.size(), 32'd0);
        chk("link_change_count", n_lc_seen, n_lc_exp);
        // Reset mid-operation returns everything to reset values at once.
        rst_n = 1'b0;
        #1;
        chk("midrst_phy_rst_n", {31'd0, phy_rst_n}, 32'd0);
        chk("midrst_status", {26'd0, cmd_valid, speed, link_up, link_change, timeout_err},
            32'b010000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
